// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Holds op encodings, the controller state type and the divider step count.
package mdu_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_STEPS = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIV  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } mdu_state_e;

  function automatic logic is_div_op(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Restoring radix-2 divider datapath on operand magnitudes.
// One quotient bit per step; load primes the shift registers.
module mdu_div
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem,
  output logic [XLEN-1:0] quot
);

  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            fits;

  // The trial difference always fits in XLEN bits when the subtract is taken.
  assign shifted = {rem_q, quot_q[XLEN-1]};
  assign fits    = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[XLEN-1:0] - dvs_q;

  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    dvs_d  = dvs_q;
    if (load) begin
      rem_d  = '0;
      quot_d = dividend;
      dvs_d  = divisor;
    end else if (step) begin
      rem_d  = fits ? diff : shifted[XLEN-1:0];
      quot_d = {quot_q[XLEN-2:0], fits};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
    end
  end

  assign rem  = rem_q;
  assign quot = quot_q;

endmodule

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller owning HI/LO: single-cycle MULT/MULTU, MTHI/MTLO,
// and an iterative DIV/DIVU compiled in only when MDU_DIV_EN is defined.
module mdu_ctrl
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic [1:0]  opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        hiwriteE,
  input  logic        lowriteE,
  input  logic [31:0] wdataE,
  input  logic        flushE,
  output logic        stallE,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] idle_hi, idle_lo;
  logic [63:0] mul_a, mul_b, mul_p;
  logic        op_signed;
  logic        start_ok;

  assign op_signed = is_signed_op(opE);
  assign start_ok  = startE & ~flushE;

  // Extending to 64 bits lets one unsigned multiplier serve both signednesses.
  assign mul_a = {{32{op_signed & srcaE[31]}}, srcaE};
  assign mul_b = {{32{op_signed & srcbE[31]}}, srcbE};
  assign mul_p = mul_a * mul_b;

  // A start (even a flushed one) shadows MTHI/MTLO in the same cycle.
  always_comb begin
    idle_hi = hi_q;
    idle_lo = lo_q;
    if (startE) begin
      if (start_ok && !is_div_op(opE)) begin
        idle_hi = mul_p[63:32];
        idle_lo = mul_p[31:0];
      end
    end else begin
      if (hiwriteE) idle_hi = wdataE;
      if (lowriteE) idle_lo = wdataE;
    end
  end

`ifdef MDU_DIV_EN
  mdu_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_load, div_step;
  logic [31:0] div_rem, div_quot;

  assign a_neg = op_signed & srcaE[31];
  assign b_neg = op_signed & srcbE[31];
  assign a_mag = a_neg ? (32'd0 - srcaE) : srcaE;
  assign b_mag = b_neg ? (32'd0 - srcbE) : srcbE;

  mdu_div u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .rem      (div_rem),
    .quot     (div_quot)
  );

  // Quotient is never negated for a zero divisor so x/0 always yields all ones.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_load = 1'b0;
    div_step = 1'b0;
    unique case (state_q)
      IDLE: begin
        hi_d = idle_hi;
        lo_d = idle_lo;
        if (start_ok && is_div_op(opE)) begin
          div_load = 1'b1;
          q_neg_d  = (a_neg ^ b_neg) & (srcbE != 32'd0);
          r_neg_d  = a_neg;
          cnt_d    = '0;
          state_d  = DIV;
        end
      end
      DIV: begin
        if (flushE) begin
          state_d = IDLE;
        end else begin
          div_step = 1'b1;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'(DIV_STEPS - 1)) state_d = FIX;
        end
      end
      FIX: begin
        if (flushE) begin
          state_d = IDLE;
        end else begin
          res_lo_d = q_neg_q ? (32'd0 - div_quot) : div_quot;
          res_hi_d = r_neg_q ? (32'd0 - div_rem) : div_rem;
          state_d  = DONE;
        end
      end
      DONE: begin
        hi_d    = res_hi_q;
        lo_d    = res_lo_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign stallE = ((state_q == IDLE) && startE && is_div_op(opE)) ||
                  (state_q == DIV) || (state_q == FIX);
  assign busy   = (state_q != IDLE);
`else
  always_comb begin
    hi_d = idle_hi;
    lo_d = idle_lo;
  end

  assign stallE = 1'b0;
  assign busy   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl with a HI/LO scoreboard; division cases follow MDU_DIV_EN.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE, srcbE;
  logic        hiwriteE, lowriteE;
  logic [31:0] wdataE;
  logic        flushE;
  logic        stallE;
  logic [31:0] hi, lo;
  logic        busy;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  mdu_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .startE   (startE),
    .opE      (opE),
    .srcaE    (srcaE),
    .srcbE    (srcbE),
    .hiwriteE (hiwriteE),
    .lowriteE (lowriteE),
    .wdataE   (wdataE),
    .flushE   (flushE),
    .stallE   (stallE),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic start, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic hiw, input logic low,
                               input logic [31:0] wd, input logic flush);
    startE   = start;
    opE      = op;
    srcaE    = a;
    srcbE    = b;
    hiwriteE = hiw;
    lowriteE = low;
    wdataE   = wd;
    flushE   = flush;
  endtask

  task automatic idle();
    applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic expectHiLo(input string tag, input logic [31:0] eh,
                            input logic [31:0] el);
    exp_t e;
    e.tag = tag;
    e.hi  = eh;
    e.lo  = el;
    sb_q.push_back(e);
  endtask

  task automatic checkScoreboard();
    exp_t e;
    if (sb_q.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      checkOutput({e.tag, "_hi"}, hi, e.hi);
      checkOutput({e.tag, "_lo"}, lo, e.lo);
    end
  endtask

  task automatic doMult(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    expectHiLo(tag, eh, el);
    applyStimulus(1'b1, op, a, b, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput({tag, "_stall_pre"}, {31'd0, stallE}, 32'd0);
    tick();
    idle();
    checkOutput({tag, "_stall_post"}, {31'd0, stallE}, 32'd0);
    checkScoreboard();
  endtask

  task automatic preload(input logic [31:0] vh, input logic [31:0] vl);
    applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0, 1'b1, 1'b0, vh, 1'b0);
    tick();
    applyStimulus(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b1, vl, 1'b0);
    tick();
    idle();
  endtask

`ifdef MDU_DIV_EN
  task automatic runDiv(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit noise);
    int stall_cycles;
    stall_cycles = 0;
    expectHiLo(tag, eh, el);
    applyStimulus(1'b1, op, a, b, 1'b0, 1'b0, 32'd0, 1'b0);
    while (stallE === 1'b1 && stall_cycles < 100) begin
      stall_cycles++;
      tick();
      if (noise) applyStimulus(1'b1, OP_MULT, 32'd3, 32'd3, 1'b0, 1'b0, 32'd0, 1'b0);
      else idle();
    end
    checkOutput({tag, "_stall_cycles"}, 32'(stall_cycles), 32'd34);
    checkOutput({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    tick();
    idle();
    checkOutput({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    checkScoreboard();
  endtask
`endif

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_stall", {31'd0, stallE}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    doMult("mult_neg", OP_MULT, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    doMult("multu_big", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    doMult("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    expectHiLo("mthi_mtlo", 32'h0000_0011, 32'h0000_0022);
    preload(32'h11, 32'h22);
    checkScoreboard();

    // A multiply in the same cycle as MTHI/MTLO must win.
    expectHiLo("start_over_mt", 32'd0, 32'd20);
    applyStimulus(1'b1, OP_MULTU, 32'd4, 32'd5, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    tick();
    idle();
    checkScoreboard();

    preload(32'h11, 32'h22);
    expectHiLo("flush_idle_mult", 32'h11, 32'h22);
    applyStimulus(1'b1, OP_MULT, 32'd3, 32'd3, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    idle();
    checkScoreboard();

`ifdef MDU_DIV_EN
    runDiv("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    runDiv("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    runDiv("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
    runDiv("div_m5_0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
    runDiv("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b1);
    runDiv("div_mixed", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);

    // Flush ten cycles into the iteration.
    preload(32'h11, 32'h22);
    applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    idle();
    repeat (10) tick();
    flushE = 1'b1;
    tick();
    flushE = 1'b0;
    checkOutput("flush_stall", {31'd0, stallE}, 32'd0);
    checkOutput("flush_busy", {31'd0, busy}, 32'd0);
    expectHiLo("flush_now", 32'h11, 32'h22);
    checkScoreboard();
    repeat (40) tick();
    expectHiLo("flush_later", 32'h11, 32'h22);
    checkScoreboard();

    applyStimulus(1'b1, OP_DIV, 32'd9, 32'd3, 1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    idle();
    checkOutput("flush_idle_div_busy", {31'd0, busy}, 32'd0);

    // Reset twenty cycles into the iteration.
    applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    idle();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_stall", {31'd0, stallE}, 32'd0);
    expectHiLo("midrst", 32'd0, 32'd0);
    checkScoreboard();
    doMult("post_rst_multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);
`else
    preload(32'h11, 32'h22);
    expectHiLo("div_noop", 32'h11, 32'h22);
    applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("div_noop_stall", {31'd0, stallE}, 32'd0);
    tick();
    idle();
    checkOutput("div_noop_busy", {31'd0, busy}, 32'd0);
    repeat (40) tick();
    checkScoreboard();

    applyStimulus(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    idle();
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    expectHiLo("midrst", 32'd0, 32'd0);
    checkScoreboard();
    doMult("post_rst_multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port startE, input, 1; execute-stage multiply/divide instruction present this cycle.
REQ-004 SHALL have port opE, input, 2; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports srcaE, srcbE, input, 32 each; rs and rt operands.
REQ-006 SHALL have ports hiwriteE, lowriteE, input, 1 each, plus wdataE, input, 32; MTHI/MTLO write.
REQ-007 SHALL have port flushE, input, 1; execute-stage flush, aborts any division in progress.
REQ-008 SHALL have port stallE, output, 1; holds the fetch, decode and execute stages while high.
REQ-009 SHALL have ports hi, lo, output, 32 each; architectural HI/LO registers.
REQ-010 SHALL have port busy, output, 1; high whenever the FSM is not IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, DIV, FIX and DONE.
REQ-012 SHALL complete MULT/MULTU in IDLE in 1 cycle: at the edge where startE=1, {hi,lo} <= 64-bit signed/unsigned product; stallE stays 0.
REQ-013 SHALL go IDLE->DIV on startE with a DIV/DIVU op, latching operand magnitudes and result signs, and clearing the 5-bit iteration counter.
REQ-014 SHALL perform one restoring radix-2 step per cycle in DIV for 32 cycles, then go DIV->FIX when counter=31.
REQ-015 SHALL negate the quotient in FIX when dividend and divisor signs differ (DIV only), and negate the remainder when the dividend is negative; FIX->DONE.
REQ-016 SHALL write hi=remainder and lo=quotient on the DONE edge, then go DONE->IDLE.
REQ-017 SHALL drive stallE = (state==IDLE & startE & divide op) | state==DIV | state==FIX; stallE=0 in DONE, so 34 stall cycles per division.
REQ-018 SHALL make division by zero finish with normal latency and give lo=0xFFFFFFFF, hi=srcaE.
REQ-019 SHALL give lo=0x80000000, hi=0 for DIV 0x80000000 / 0xFFFFFFFF, with no trap.
REQ-020 SHALL return to IDLE on the next edge when flushE=1 in DIV or FIX, leaving hi/lo unchanged; flushE in IDLE suppresses a same-cycle start.
REQ-021 SHALL apply MTHI/MTLO in IDLE only, 1-cycle latency; startE takes priority over hiwriteE/lowriteE in the same cycle.
REQ-022 SHALL ignore startE while the FSM is not IDLE.

Reset
REQ-023 SHALL make rst=1 force state=IDLE, hi=0, lo=0, counter=0, stallE=0 and busy=0 at the next edge, including mid-division.
REQ-024 SHALL give rst priority over flushE, startE and MTHI/MTLO.

Configuration
REQ-025 SHALL compile the divider FSM, divider datapath and DIV/FIX/DONE states in when macro MDU_DIV_EN is defined.
REQ-026 SHALL, without MDU_DIV_EN, treat DIV/DIVU as no-ops (hi/lo unchanged, stallE never 1, busy constant 0); MULT/MULTU and MTHI/MTLO are unaffected.

Structure
REQ-027 SHALL place op encodings, the FSM state typedef and DIV_STEPS=32 in shared package mdu_pkg.
REQ-028 SHALL implement the remainder/quotient shift registers and one subtract step in sub-module mdu_div; FSM, sign fixup and HI/LO stay in mdu_ctrl.

Verification
REQ-029 SHALL cover MULT 3 x 0xFFFFFFFE -> hi=0xFFFFFFFF, lo=0xFFFFFFFA after 1 edge, stallE never 1.
REQ-030 SHALL cover DIVU 100 / 7 -> stallE high for exactly 34 cycles, then lo=14, hi=2.
REQ-031 SHALL cover DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 SHALL cover DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5, normal latency.
REQ-033 SHALL cover flushE at DIV cycle 10, with hi/lo preloaded to 0x11/0x22 -> IDLE next cycle, stallE=0, hi/lo unchanged.
REQ-034 SHALL cover rst at DIV cycle 20 -> next edge hi=lo=0, busy=0, and a following MULTU 0xFFFFFFFF x 2 gives hi=1, lo=0xFFFFFFFE.
